two_of_five_tx: RTL and testbench

TWO_OF_FIVE_TX -- requirements
Module: two_of_five_tx

---
 rtl/two_of_five_tx.sv | 113 +++++++++++
 tb/tb_two_of_five_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/two_of_five_tx.sv
// Serialises a decimal digit as a 2-of-5 codeword on sdata/sframe.
// Optional one-cycle inter-frame gap is enabled by defining TWO_OF_FIVE_GAP_EN.
module two_of_five_tx #(
    parameter int MSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit,
    input  logic       valid,
    output logic       ready,
    output logic       sdata,
    output logic       sframe,
    output logic       done,
    output logic       err
);

    // state | meaning
    // IDLE  | ready for a digit; an out-of-range digit raises err next cycle
    // SHIFT | five codeword bits on sdata, done on the last one
    // GAP   | one dead cycle between frames (TWO_OF_FIVE_GAP_EN only)
`ifdef TWO_OF_FIVE_GAP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t     state, state_nxt;
    logic [4:0] sr, sr_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       err_q, err_nxt;
    logic       accept;

    // Codeword bits ordered a..e from bit 4 down to bit 0.
    function automatic logic [4:0] encode(input logic [3:0] d);
        logic [4:0] c;
        case (d)
            4'd0:    c = 5'b10100;
            4'd1:    c = 5'b00011;
            4'd2:    c = 5'b00110;
            4'd3:    c = 5'b00101;
            4'd4:    c = 5'b01001;
            4'd5:    c = 5'b01010;
            4'd6:    c = 5'b01100;
            4'd7:    c = 5'b11000;
            4'd8:    c = 5'b10001;
            4'd9:    c = 5'b10010;
            default: c = 5'b00000;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            sr    <= sr_nxt;
            cnt   <= cnt_nxt;
            err_q <= err_nxt;
        end
    end

    assign accept = valid && ready;

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (digit <= 4'd9) begin
                        sr_nxt    = encode(digit);
                        cnt_nxt   = '0;
                        state_nxt = SHIFT;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (MSB_FIRST != 0) sr_nxt = {sr[3:0], 1'b0};
                else                sr_nxt = {1'b0, sr[4:1]};
                if (cnt == 3'd4) begin
                    cnt_nxt = '0;
                    sr_nxt  = '0;
`ifdef TWO_OF_FIVE_GAP_EN
                    state_nxt = GAP;
`else
                    state_nxt = IDLE;
`endif
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
`ifdef TWO_OF_FIVE_GAP_EN
            GAP: state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign ready  = (state == IDLE);
    assign sframe = (state == SHIFT);
    assign sdata  = sframe && ((MSB_FIRST != 0) ? sr[4] : sr[0]);
    assign done   = sframe && (cnt == 3'd4);
    assign err    = err_q;

endmodule

// File: tb/tb_two_of_five_tx.sv
// Scoreboard bench: stimulus queues expected frames, a negedge monitor checks them
// on an MSB-first and an LSB-first instance driven in parallel.
module tb_two_of_five_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       valid = 1'b0;
    logic [1:0] ready_v, sdata_v, sframe_v, done_v, err_v;

    two_of_five_tx #(.MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .digit(digit), .valid(valid),
        .ready(ready_v[0]), .sdata(sdata_v[0]), .sframe(sframe_v[0]),
        .done(done_v[0]), .err(err_v[0])
    );

    two_of_five_tx #(.MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .digit(digit), .valid(valid),
        .ready(ready_v[1]), .sdata(sdata_v[1]), .sframe(sframe_v[1]),
        .done(done_v[1]), .err(err_v[1])
    );

    always #5 clk = ~clk;

`ifdef TWO_OF_FIVE_GAP_EN
    localparam int PERIOD = 7;
`else
    localparam int PERIOD = 6;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    always @(posedge clk) cycle++;

    // bit 5 set marks an expected err pulse; otherwise bits 4:0 are the frame in wire order
    logic [5:0] q_msb[$];
    logic [5:0] q_lsb[$];
    bit b2b = 0;
    bit have_start = 0;
    int last_start = 0;

    function automatic logic [4:0] code(input int d);
        case (d)
            0: return 5'b10100;  1: return 5'b00011;  2: return 5'b00110;
            3: return 5'b00101;  4: return 5'b01001;  5: return 5'b01010;
            6: return 5'b01100;  7: return 5'b11000;  8: return 5'b10001;
            9: return 5'b10010;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic logic [4:0] rev5(input logic [4:0] c);
        return {c[0], c[1], c[2], c[3], c[4]};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    int         nbits[2] = '{0, 0};
    logic [4:0] rx[2];
    always @(negedge clk) begin
        logic [5:0] e;
        int sz;
        if (!rst_n) begin
            nbits = '{0, 0};
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sframe_v[i]) begin
                    if (i == 0 && nbits[0] == 0 && b2b) begin
                        if (have_start) check("frame_spacing", cycle - last_start, PERIOD);
                        last_start = cycle;
                        have_start = 1;
                    end
                    rx[i] = {rx[i][3:0], sdata_v[i]};
                    nbits[i]++;
                end else begin
                    check("sdata_outside_frame", int'(sdata_v[i]), 0);
                    if (nbits[i] != 0) begin
                        check("frame_truncated", nbits[i], 5);
                        nbits[i] = 0;
                    end
                end
                if (done_v[i]) begin
                    check("done_on_bit5", nbits[i], 5);
                    check("two_ones", $countones(rx[i]), 2);
                    sz = (i == 0) ? q_msb.size() : q_lsb.size();
                    if (sz == 0) check("unexpected_frame", 1, 0);
                    else begin
                        if (i == 0) e = q_msb.pop_front(); else e = q_lsb.pop_front();
                        check(i == 0 ? "frame_msb" : "frame_lsb", int'({1'b0, rx[i]}), int'(e));
                    end
                    nbits[i] = 0;
                end
                if (err_v[i]) begin
                    sz = (i == 0) ? q_msb.size() : q_lsb.size();
                    if (sz == 0) check("unexpected_err", 1, 0);
                    else begin
                        if (i == 0) e = q_msb.pop_front(); else e = q_lsb.pop_front();
                        check("err_pulse", 32, int'(e));
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!ready_v[0] && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20) check("ready_timeout", 0, 1);
    endtask

    // Presents d and returns 1 time unit after the accepting edge.
    task automatic send(input int d, input bit hold);
        digit = 4'(d);
        valid = 1'b1;
        wait_ready();
        if (d <= 9) begin
            q_msb.push_back({1'b0, code(d)});
            q_lsb.push_back({1'b0, rev5(code(d))});
        end else begin
            q_msb.push_back(6'b100000);
            q_lsb.push_back(6'b100000);
        end
        @(posedge clk); #1;
        if (!hold) valid = 1'b0;
        if (d <= 9) begin
            check("latency_sframe", int'(sframe_v[0]), 1);
            check("ready_low_in_shift", int'(ready_v[0]), 0);
        end else begin
            check("err_high", int'(err_v[0]), 1);
            check("err_sframe_low", int'(sframe_v[0]), 0);
            check("err_ready_high", int'(ready_v[0]), 1);
            @(posedge clk); #1;
            check("err_one_cycle", int'(err_v[0]), 0);
        end
    endtask

    task automatic finish_frame();
        wait_ready();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", int'(ready_v[0]), 1);
        check("rst_sdata", int'(sdata_v[0]), 0);
        check("rst_sframe", int'(sframe_v[0]), 0);
        check("rst_done", int'(done_v[0]), 0);
        check("rst_err", int'(err_v[0]), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // digit 7, explicit bit-by-bit view on the MSB-first instance
        send(7, 0);
        check("d7_bit1", int'(sdata_v[0]), 1);
        @(posedge clk); #1; check("d7_bit2", int'(sdata_v[0]), 1);
        @(posedge clk); #1; check("d7_bit3", int'(sdata_v[0]), 0);
        @(posedge clk); #1; check("d7_done_early", int'(done_v[0]), 0);
        @(posedge clk); #1; check("d7_done", int'(done_v[0]), 1);
        check("d7_sframe5", int'(sframe_v[0]), 1);
        @(posedge clk); #1;
`ifndef TWO_OF_FIVE_GAP_EN
        check("d7_ready_after", int'(ready_v[0]), 1);
`endif
        check("d7_sframe_after", int'(sframe_v[0]), 0);
        finish_frame();

        send(8, 0); finish_frame();
        send(4, 0); finish_frame();

        have_start = 0;
        b2b = 1;
        send(1, 1); send(2, 1); send(3, 1);
        valid = 1'b0;
        finish_frame();
        b2b = 0;

        send(12, 0);
        send(0, 0); finish_frame();

        // reset during the third bit of digit 5
        send(5, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("d5_bit3_sframe", int'(sframe_v[0]), 1);
        rst_n = 1'b0;
        #1;
        check("abort_sdata", int'(sdata_v[0]), 0);
        check("abort_sframe", int'(sframe_v[0]), 0);
        check("abort_done", int'(done_v[0]), 0);
        check("abort_ready", int'(ready_v[0]), 1);
        q_msb.delete();
        q_lsb.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(6, 0);
        finish_frame();

        have_start = 0;
        b2b = 1;
        for (int d = 0; d < 10; d++) send(d, 1);
        valid = 1'b0;
        finish_frame();
        b2b = 0;

        repeat (10) @(posedge clk);
        #1;
        check("q_msb_drained", q_msb.size(), 0);
        check("q_lsb_drained", q_lsb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
